// File: rtl/parking_lot_ctrl.sv
// parking_lot_ctrl
//   Occupancy controller for a lot of SPOTS spaces. An entry takes the lowest
//   free space and an exit releases a named space. Each accepted event runs a
//   gate door sequence. Illegal requests raise a one-cycle reject pulse.
//
//   Optional feature macro: PARKING_DOOR_BLINK_EN
//     defined   : the door stays open for BLINK_COUNT on/off LED pairs of
//                 BLINK_DIV cycles per phase. Requests that arrive during
//                 the sequence are rejected.
//     undefined : doorOpen_o is a one-cycle pulse per accepted event,
//                 blinkLED_o is tied low and requests are accepted every cycle.
//
//   state     | meaning
//   ----------+--------------------------------------------
//   IDLE      | door closed, requests evaluated
//   BLINK_ON  | door open, LED on for BLINK_DIV cycles
//   BLINK_OFF | door open, LED off for BLINK_DIV cycles
//
//   Ports
//     clk_i          : clock, rising edge
//     reset_i        : synchronous active-high reset
//     enter_i        : entry request (level)
//     exit_i         : exit request (level)
//     exitLocation_i : 0-based space being vacated, valid with exit_i
//     occupancy_o    : bit i set = space i occupied
//     freeCount_o    : number of free spaces
//     nextParking_o  : 1-based index of the lowest free space, 0 when full
//     isFull_o       : all spaces occupied
//     doorOpen_o     : door sequence active
//     blinkLED_o     : LED drive during the door sequence
//     reject_o       : one-cycle pulse after an illegal request
module parking_lot_ctrl #(
  parameter int SPOTS       = 4,
  parameter int LOC_W       = $clog2(SPOTS),
  parameter int CNT_W       = $clog2(SPOTS + 1),
  parameter int BLINK_DIV   = 25_000_000,
  parameter int BLINK_COUNT = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enter_i,
  input  logic             exit_i,
  input  logic [LOC_W-1:0] exitLocation_i,
  output logic [SPOTS-1:0] occupancy_o,
  output logic [CNT_W-1:0] freeCount_o,
  output logic [CNT_W-1:0] nextParking_o,
  output logic             isFull_o,
  output logic             doorOpen_o,
  output logic             blinkLED_o,
  output logic             reject_o
);

  logic [SPOTS-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] free_q, free_d;
  logic [CNT_W-1:0] next_q, next_d;
  logic             full_q, full_d;
  logic             door_q, blink_q, reject_q;

  logic evaluate;   // requests are being looked at this cycle
  logic accept;     // a legal enter or exit is taken this cycle
  logic req_bad;    // an illegal enter or exit is seen this cycle

  function automatic logic [CNT_W-1:0] count_free(input logic [SPOTS-1:0] occ);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < SPOTS; i++) begin
      if (!occ[i]) n = n + 1'b1;
    end
    return n;
  endfunction

  // Scan downwards so the lowest free space is the final assignment.
  function automatic logic [CNT_W-1:0] lowest_free(input logic [SPOTS-1:0] occ);
    logic [CNT_W-1:0] idx;
    idx = '0;
    for (int i = SPOTS - 1; i >= 0; i--) begin
      if (!occ[i]) idx = CNT_W'(i + 1);
    end
    return idx;
  endfunction

  always_comb begin
    logic loc_valid, exit_hit, enter_only, exit_only, enter_ok, exit_ok;
    // LOC_W can address past SPOTS when SPOTS is not a power of two.
    loc_valid  = int'(exitLocation_i) < SPOTS;
    exit_hit   = loc_valid && occ_q[exitLocation_i];
    enter_only = enter_i && !exit_i;
    exit_only  = exit_i && !enter_i;
    enter_ok   = enter_only && !full_q;
    exit_ok    = exit_only && exit_hit;

    accept  = evaluate && (enter_ok || exit_ok);
    req_bad = evaluate && ((enter_only && full_q) || (exit_only && !exit_hit));

    occ_d = occ_q;
    if (evaluate && enter_ok) begin
      occ_d = occ_q | (SPOTS'(1) << (next_q - 1'b1));
    end else if (evaluate && exit_ok) begin
      occ_d = occ_q & ~(SPOTS'(1) << exitLocation_i);
    end

    // Status is derived from the next occupancy so it moves with the bitmap.
    free_d = count_free(occ_d);
    next_d = lowest_free(occ_d);
    full_d = &occ_d;
  end

`ifdef PARKING_DOOR_BLINK_EN
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BLINK_ON  = 2'd1,
    BLINK_OFF = 2'd2
  } state_e;

  localparam int PH_W = $clog2(BLINK_DIV + 1);
  localparam int PR_W = $clog2(BLINK_COUNT + 1);
  localparam logic [PH_W-1:0] PH_RELOAD = PH_W'(BLINK_DIV - 1);
  localparam logic [PR_W-1:0] PR_LAST   = PR_W'(BLINK_COUNT - 1);

  state_e           state_q;
  logic [PH_W-1:0]  phase_q;   // down-counter, phase ends at zero
  logic [PR_W-1:0]  pair_q;    // completed on/off pairs

  assign evaluate = (state_q == IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      pair_q   <= '0;
      occ_q    <= '0;
      free_q   <= CNT_W'(SPOTS);
      next_q   <= CNT_W'(1);
      full_q   <= 1'b0;
      door_q   <= 1'b0;
      blink_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      free_q <= free_d;
      next_q <= next_d;
      full_q <= full_d;
      case (state_q)
        IDLE: begin
          reject_q <= req_bad;
          if (accept) begin
            state_q <= BLINK_ON;
            phase_q <= PH_RELOAD;
            pair_q  <= '0;
            door_q  <= 1'b1;
            blink_q <= 1'b1;
          end
        end
        BLINK_ON: begin
          // Requests are not queued while the door is busy.
          reject_q <= enter_i || exit_i;
          if (phase_q == '0) begin
            state_q <= BLINK_OFF;
            phase_q <= PH_RELOAD;
            blink_q <= 1'b0;
          end else begin
            phase_q <= phase_q - 1'b1;
          end
        end
        BLINK_OFF: begin
          reject_q <= enter_i || exit_i;
          if (phase_q == '0) begin
            if (pair_q == PR_LAST) begin
              state_q <= IDLE;
              door_q  <= 1'b0;
            end else begin
              state_q <= BLINK_ON;
              pair_q  <= pair_q + 1'b1;
              phase_q <= PH_RELOAD;
              blink_q <= 1'b1;
            end
          end else begin
            phase_q <= phase_q - 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          door_q   <= 1'b0;
          blink_q  <= 1'b0;
          reject_q <= 1'b0;
        end
      endcase
    end
  end
`else
  assign evaluate = 1'b1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occ_q    <= '0;
      free_q   <= CNT_W'(SPOTS);
      next_q   <= CNT_W'(1);
      full_q   <= 1'b0;
      door_q   <= 1'b0;
      blink_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      free_q   <= free_d;
      next_q   <= next_d;
      full_q   <= full_d;
      door_q   <= accept;
      blink_q  <= 1'b0;
      reject_q <= req_bad;
    end
  end
`endif

  assign occupancy_o   = occ_q;
  assign freeCount_o   = free_q;
  assign nextParking_o = next_q;
  assign isFull_o      = full_q;
  assign doorOpen_o    = door_q;
  assign blinkLED_o    = blink_q;
  assign reject_o      = reject_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Testbench for parking_lot_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the lot (array of spaces plus a door timer).
module tb_parking_lot_ctrl;
  localparam int SPOTS       = 4;
  localparam int BLINK_DIV   = 2;
  localparam int BLINK_COUNT = 3;
`ifdef PARKING_DOOR_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif
  localparam int SEQ_LEN = BLINK_EN ? 2 * BLINK_COUNT * BLINK_DIV : 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0;
  logic       exit_s = 1'b0;
  logic [1:0] loc = 2'd0;
  logic [3:0] occupancy;
  logic [2:0] freeCount, nextParking;
  logic       isFull, doorOpen, blinkLED, reject;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  parking_lot_ctrl #(
    .SPOTS(SPOTS), .BLINK_DIV(BLINK_DIV), .BLINK_COUNT(BLINK_COUNT)
  ) dut (
    .clk_i(clk), .reset_i(reset), .enter_i(enter), .exit_i(exit_s),
    .exitLocation_i(loc), .occupancy_o(occupancy), .freeCount_o(freeCount),
    .nextParking_o(nextParking), .isFull_o(isFull), .doorOpen_o(doorOpen),
    .blinkLED_o(blinkLED), .reject_o(reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_occ[SPOTS];
  int m_busy = 0;   // door-open cycles remaining, counting the current one
  int m_pos  = 0;   // cycles elapsed in the current door sequence
  bit m_rej  = 0;

  function automatic int m_lowest();
    for (int i = 0; i < SPOTS; i++) if (!m_occ[i]) return i;
    return -1;
  endfunction

  function automatic int m_occ_val();
    int v = 0;
    for (int i = 0; i < SPOTS; i++) if (m_occ[i]) v += (1 << i);
    return v;
  endfunction

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < SPOTS; i++) if (!m_occ[i]) n++;
    return n;
  endfunction

  always @(posedge clk) begin : model
    int fi;
    bit acc;
    if (reset) begin
      for (int i = 0; i < SPOTS; i++) m_occ[i] = 1'b0;
      m_busy = 0;
      m_pos  = 0;
      m_rej  = 1'b0;
    end else if (BLINK_EN && m_busy > 0) begin
      m_rej = enter || exit_s;
      m_busy--;
      m_pos++;
    end else begin
      m_rej = 1'b0;
      acc   = 1'b0;
      fi    = m_lowest();
      if (enter && !exit_s) begin
        if (fi < 0) m_rej = 1'b1;
        else begin m_occ[fi] = 1'b1; acc = 1'b1; end
      end else if (exit_s && !enter) begin
        if (int'(loc) < SPOTS && m_occ[loc]) begin m_occ[loc] = 1'b0; acc = 1'b1; end
        else m_rej = 1'b1;
      end
      m_busy = acc ? SEQ_LEN : 0;
      m_pos  = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("occupancy", int'(occupancy), m_occ_val());
      chk("freeCount", int'(freeCount), m_free());
      chk("nextParking", int'(nextParking), m_lowest() + 1);
      chk("isFull", int'(isFull), int'(m_free() == 0));
      chk("doorOpen", int'(doorOpen), int'(m_busy > 0));
      chk("blinkLED", int'(blinkLED),
          int'(BLINK_EN && m_busy > 0 && ((m_pos / BLINK_DIV) % 2 == 0)));
      chk("reject", int'(reject), int'(m_rej));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit e, input bit x, input int l);
    @(negedge clk);
    enter  = e;
    exit_s = x;
    loc    = 2'(l);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (doorOpen && n < 100) begin
      tick(0, 0, 0);
      n++;
    end
    chk("door_closed", int'(doorOpen), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_occ"}, int'(occupancy), 0);
    chk({tag, "_free"}, int'(freeCount), 4);
    chk({tag, "_next"}, int'(nextParking), 1);
    chk({tag, "_full"}, int'(isFull), 0);
    chk({tag, "_door"}, int'(doorOpen), 0);
    chk({tag, "_blink"}, int'(blinkLED), 0);
    chk({tag, "_reject"}, int'(reject), 0);
  endtask

  initial begin
    int door_cnt;
    logic [11:0] pat;

    tick(0, 0, 0);
    tick(0, 0, 0);
    chk_en = 1'b1;
    reset  = 1'b0;
    chk_reset_vals("rst");

    // Single entry and the door sequence it starts.
    tick(1, 0, 0);
    chk("t1_occ", int'(occupancy), 1);
    chk("t1_free", int'(freeCount), 3);
    chk("t1_next", int'(nextParking), 2);
    chk("t1_door", int'(doorOpen), 1);
    door_cnt = 0;
    pat = '0;
    for (int i = 0; i < 14; i++) begin
      door_cnt += int'(doorOpen);
      if (i < 12) pat[11-i] = blinkLED;
      tick(0, 0, 0);
    end
`ifdef PARKING_DOOR_BLINK_EN
    chk("t1_door_cycles", door_cnt, 12);
    chk("t1_blink_pattern", int'(pat), 12'b110011001100);
`else
    chk("t1_door_cycles", door_cnt, 1);
    chk("t1_blink_pattern", int'(pat), 0);
`endif

    // Fill the lot, then one entry too many.
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0);
      wait_idle();
    end
    chk("t2_occ", int'(occupancy), 15);
    chk("t2_full", int'(isFull), 1);
    chk("t2_next", int'(nextParking), 0);
    chk("t2_free", int'(freeCount), 0);
    tick(1, 0, 0);
    chk("t2_reject", int'(reject), 1);
    chk("t2_no_door", int'(doorOpen), 0);
    chk("t2_occ_kept", int'(occupancy), 15);
    tick(0, 0, 0);
    chk("t2_reject_one_cycle", int'(reject), 0);

    // Exit from space 2, then the same space again.
    tick(0, 1, 2);
    chk("t3_occ", int'(occupancy), 11);
    chk("t3_next", int'(nextParking), 3);
    chk("t3_full", int'(isFull), 0);
    wait_idle();
    tick(0, 1, 2);
    chk("t3_reject", int'(reject), 1);
    chk("t3_occ_kept", int'(occupancy), 11);
    tick(0, 0, 0);

    // Simultaneous enter and exit, then entry during a door sequence.
    reset = 1'b1;
    tick(0, 0, 0);
    reset = 1'b0;
    tick(1, 0, 0);
    wait_idle();
    tick(1, 0, 0);
    wait_idle();
    tick(1, 1, 0);
    chk("t4_both_occ", int'(occupancy), 3);
    chk("t4_both_reject", int'(reject), 0);
    chk("t4_both_door", int'(doorOpen), 0);
    tick(1, 0, 0);
    chk("t4_occ", int'(occupancy), 7);
`ifdef PARKING_DOOR_BLINK_EN
    tick(1, 0, 0);
    chk("t4_busy_reject", int'(reject), 1);
    chk("t4_busy_occ", int'(occupancy), 7);
    chk("t4_busy_blink", int'(blinkLED), 1);
`endif

    // Reset in the middle of the door sequence.
    reset = 1'b1;
    tick(0, 0, 0);
    reset = 1'b0;
    chk_reset_vals("t5");

`ifndef PARKING_DOOR_BLINK_EN
    // Back-to-back entries with no blink phase.
    tick(1, 0, 0);
    chk("t6_occ1", int'(occupancy), 1);
    chk("t6_door1", int'(doorOpen), 1);
    tick(1, 0, 0);
    chk("t6_occ2", int'(occupancy), 3);
    chk("t6_door2", int'(doorOpen), 1);
    tick(1, 0, 0);
    chk("t6_occ3", int'(occupancy), 7);
    chk("t6_door3", int'(doorOpen), 1);
    chk("t6_blink", int'(blinkLED), 0);
    tick(0, 0, 0);
    chk("t6_door_off", int'(doorOpen), 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit e, x;
      r = int'($urandom_range(0, 99));
      e = (r < 40) || (r >= 95);
      x = (r >= 40 && r < 70) || (r >= 95);
      reset = ($urandom_range(0, 299) == 0);
      tick(e, x, int'($urandom_range(0, 3)));
    end
    reset = 1'b0;
    tick(0, 0, 0);
    tick(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/parking_lot_ctrl.md
# parking_lot_ctrl

Parametrised parking-lot occupancy controller and the successor to the fixed four-spot lot FSM. It tracks `SPOTS` individual spaces as an occupancy bitmap and allocates the lowest free space on entry. It releases a named space on exit and derives the free-space count, the next space to use and the full flag. A gate door sequence with an optional LED blink phase runs on every accepted event, and illegal requests are flagged.

## Interface
- `SPOTS`, default 4: number of spaces, legal range 2..16.
- `LOC_W`, default `$clog2(SPOTS)`: width of a 0-based space index (derived; do not override).
- `CNT_W`, default `$clog2(SPOTS+1)`: width of counts and 1-based indices (derived).
- `BLINK_DIV`, default 25_000_000: clock cycles per blink half-period, minimum 1.
- `BLINK_COUNT`, default 3: on/off blink pairs per door sequence, minimum 1.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `enter` in 1: car requests entry; level, sampled every cycle.
- `exit` in 1: car requests exit; level, sampled every cycle.
- `exitLocation` in LOC_W: 0-based space being vacated, valid with `exit`.
- `occupancy` out SPOTS: bit i = space i occupied.
- `freeCount` out CNT_W: SPOTS minus popcount(occupancy).
- `nextParking` out CNT_W: 1-based index of lowest free space; 0 when full.
- `isFull` out 1: all spaces occupied.
- `doorOpen` out 1: door sequence active.
- `blinkLED` out 1: blink drive during door sequence.
- `reject` out 1: one-cycle pulse on an illegal request.

## Operation
- Reset values: `occupancy`=0, `freeCount`=SPOTS, `nextParking`=1, `isFull`=0, `doorOpen`=0, `blinkLED`=0, `reject`=0, FSM=IDLE.
- FSM states:
  - IDLE: accepts events.
  - BLINK_ON: `blinkLED`=1.
  - BLINK_OFF: `blinkLED`=0.
- Requests are evaluated only in IDLE.
- **Enter only, not full:** set bit (nextParking-1). Go to BLINK_ON.
- **Enter only, full:** `reject` pulse, no state change.
- **Exit only, bit `exitLocation` set:** clear that bit. Go to BLINK_ON.
- **Exit only, bit `exitLocation` clear, or `exitLocation` ≥ SPOTS:** `reject` pulse, no change.
- **enter && exit together:** ignored. No reject, no change.
- **Any enter/exit while in BLINK_ON/BLINK_OFF:** ignored, `reject` pulse. Requests are not queued.
- Phase counter: BLINK_ON and BLINK_OFF each last BLINK_DIV cycles.
- Pair counter: increments on each BLINK_OFF→BLINK_ON transition.
- After BLINK_COUNT pairs, BLINK_OFF→IDLE.
- `doorOpen` = (FSM ≠ IDLE), registered.
- `freeCount`, `nextParking` and `isFull` are registered and computed from the next-state occupancy. All status outputs therefore change on the same edge as `occupancy`.
- Counts use CNT_W arithmetic with no wrap. The bitmap makes `freeCount` in [0,SPOTS] by construction.
- `reset` mid-sequence aborts the blink and clears occupancy to the reset values.

## Timing
- Accepted event sampled at edge k: `occupancy`, counts, `isFull`, `doorOpen`=1 and `blinkLED`=1 are all valid after edge k. Latency is 1 cycle.
- `reject` is high for exactly the cycle after the offending edge.
- Door sequence length is 2·BLINK_COUNT·BLINK_DIV cycles of `doorOpen`=1.
- The first cycle with `doorOpen`=0 again accepts a new request.
- Back-to-back requests held high are each serviced once per sequence. A held `enter` re-enters after the door closes.

## Configuration
- Macro: `PARKING_DOOR_BLINK_EN`.
- **Defined:** behaviour as above.
- **Undefined:**
  - The BLINK states and counters are not compiled.
  - `blinkLED` is tied 0.
  - `doorOpen` is a one-cycle pulse after each accepted event.
  - Requests are accepted every cycle, and the in-sequence reject rule does not apply.

## Test plan
Bench parameters: SPOTS=4, BLINK_DIV=2, BLINK_COUNT=3, macro defined unless stated.
1. Reset, then pulse `enter` → `occupancy`=0001, `freeCount`=3, `nextParking`=2; `doorOpen` high 12 cycles; `blinkLED` 1,1,0,0 ×3.
2. Four spaced entries, then a fifth `enter` → `occupancy`=1111, `isFull`=1, `nextParking`=0; fifth gives `reject` 1 cycle, no door.
3. From full, `exit` with `exitLocation`=2 → `occupancy`=1011, `nextParking`=3, `isFull`=0; then `exit` on 2 again → `reject`, no change.
4. `enter` && `exit` same cycle from 0011 → no change, no reject; `enter` during blink → `reject`, occupancy unchanged.
5. `reset` asserted mid-BLINK_ON with occupancy 0111 → next cycle all outputs at reset values.
6. Macro undefined: three consecutive `enter` cycles → `occupancy` 0001→0011→0111 on consecutive edges, `doorOpen` high each of those cycles, `blinkLED`=0.
